fetch_unit: RTL

Instruction-fetch stage of the RV32I pipeline. Owns the program counter, issues requests to instruction memory over a req/gnt/rvalid interface, and fills the IF/ID pipeline register. Directly consumes the branch comparator's taken result, together with jump redirects from decode/execute. Flushes wrong-path instructions on any redirect.

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, talks req/gnt/rvalid to instruction
// memory with at most one request in flight, and fills the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        misalign_q, misalign_d;

  logic redirect;
  logic req;
  logic granted;

  // Handshake: a request is transferred in any cycle where imem_req and imem_gnt
  // are both high; imem_rvalid carries the data for the single granted request.
  assign redirect = (br_valid & br_taken) | jump;
  assign req      = ~rst & (state_q == S_REQ) & ~(id_valid_q & stall);
  assign granted  = req & imem_gnt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    misalign_d   = 1'b0;

    // Decode consumes IF/ID whenever it is not stalled.
    if (!stall) id_valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (granted) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall || !id_valid_q) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = req_pc_q;
            id_pc4_d   = req_pc_q + 32'd4;
            state_d    = S_REQ;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = req_pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = hold_instr_q;
          id_pc_d    = hold_pc_q;
          id_pc4_d   = hold_pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect overrides everything above; an in-flight or just-granted
    // request must still be retired from memory, so it is marked wrong-path.
    if (redirect) begin
      pc_d       = {target[31:2], 2'b00};
      misalign_d = |target[1:0];
      id_valid_d = 1'b0;
      if (((state_q == S_WAIT) && !imem_rvalid) || granted) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      kill_q       <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= 32'h0000_0000;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP;
      id_pc_q      <= 32'h0000_0000;
      id_pc4_q     <= 32'h0000_0004;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign misalign  = misalign_q;

endmodule
